pr_bitstream_feeder: RTL and testbench

PR_BITSTREAM_FEEDER -- requirements
Module: pr_bitstream_feeder

---
 rtl/pr_bitstream_feeder_if.sv | 24 ++
 rtl/pr_bitstream_feeder.sv | 152 +++++++++++++++
 tb/tb_pr_bitstream_feeder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pr_bitstream_feeder_if.sv
// Bitstream ROM read port and PR IP streaming port of the feeder.
// master = feeder side, slave = ROM / PR IP side.
interface pr_bitstream_feeder_if #(
  parameter int ADDR_W = 20
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              pr_start;
  logic [15:0]       pr_data;
  logic              pr_data_valid;
  logic              pr_data_ready;
  logic [2:0]        pr_status;

  modport master (
    output mem_rd, mem_addr, pr_start, pr_data, pr_data_valid,
    input  mem_rdata, pr_data_ready, pr_status
  );

  modport slave (
    input  mem_rd, mem_addr, pr_start, pr_data, pr_data_valid,
    output mem_rdata, pr_data_ready, pr_status
  );
endinterface

// File: rtl/pr_bitstream_feeder.sv
// Streams a bitstream of num_words 16-bit words from a fixed-latency ROM into
// a partial-reconfiguration IP, with start/finish handshakes, timeouts and
// sticky done/error reporting.
module pr_bitstream_feeder #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  pr_bitstream_feeder_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_PROG = 3'b100;
  localparam logic [2:0] ST_OK   = 3'b101;
  localparam logic [2:0] EC_TMO  = 3'b110;
  localparam logic [2:0] EC_ZERO = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_FINISH, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] words_q, rd_cnt, xfer_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [1:0][15:0]  fifo_q;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic              rd_pend;     // ROM data for last cycle's strobe is on mem_rdata now
  logic              st_err, pop, push, can_issue, tmo;
  logic [2:0]        credit;

  assign st_err = (bus.pr_status == 3'b001) || (bus.pr_status == 3'b010) ||
                  (bus.pr_status == 3'b011);
  assign tmo    = (tmo_cnt == TW'(TIMEOUT - 1));

  assign bus.pr_data_valid = (state == S_STREAM) && (occ != 2'd0);
  assign bus.pr_data       = fifo_q[rd_ptr];
  assign pop               = bus.pr_data_valid && bus.pr_data_ready;
  assign push              = rd_pend && (state == S_STREAM) && !st_err;

  // Buffered plus in-flight words; a slot freed by this cycle's transfer may be
  // reused immediately, which is what keeps the stream bubble-free.
  assign credit    = {1'b0, occ} + {2'b00, rd_pend};
  assign can_issue = (credit < 3'd2) || ((credit == 3'd2) && pop);

  assign bus.mem_rd   = (state == S_STREAM) && !st_err && (rd_cnt < words_q) && can_issue;
  assign bus.mem_addr = rd_cnt;
  assign bus.pr_start = (state == S_START);
  assign busy         = (state == S_START) || (state == S_STREAM) || (state == S_FINISH);

  // Control FSM together with the read counters and the 2-entry prefetch FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 3'b000;
      words_q  <= '0;
      rd_cnt   <= '0;
      xfer_cnt <= '0;
      tmo_cnt  <= '0;
      fifo_q   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= bus.mem_rd;
      tmo_cnt <= tmo_cnt + 1'b1;
      if (bus.mem_rd) rd_cnt <= rd_cnt + 1'b1;
      if (push) begin
        fifo_q[wr_ptr] <= bus.mem_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            tmo_cnt <= '0;
            done    <= 1'b0;
            if (num_words == '0) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= EC_ZERO;
            end else begin
              state    <= S_START;
              words_q  <= num_words;
              error    <= 1'b0;
              err_code <= 3'b000;
              rd_cnt   <= '0;
              xfer_cnt <= '0;
              occ      <= 2'd0;
              wr_ptr   <= 1'b0;
              rd_ptr   <= 1'b0;
            end
          end
        end
        S_START: begin
          if (bus.pr_status == ST_PROG) begin
            state   <= S_STREAM;
            tmo_cnt <= '0;
          end else if (tmo) begin
            state    <= S_ERR;
            error    <= 1'b1;
            err_code <= EC_TMO;
            tmo_cnt  <= '0;
          end
        end
        S_STREAM, S_FINISH: begin
          // Error status wins over a last-word transfer or success; the FIFO
          // is dropped and the pending ROM word is never written.
          if (st_err) begin
            state    <= S_ERR;
            error    <= 1'b1;
            err_code <= bus.pr_status;
            tmo_cnt  <= '0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
          end else if (state == S_STREAM) begin
            if (pop && (xfer_cnt == words_q - 1'b1)) begin
              state   <= S_FINISH;
              tmo_cnt <= '0;
            end
          end else if (bus.pr_status == ST_OK) begin
            state   <= S_DONE;
            done    <= 1'b1;
            tmo_cnt <= '0;
          end else if (tmo) begin
            state    <= S_ERR;
            error    <= 1'b1;
            err_code <= EC_TMO;
            tmo_cnt  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pr_bitstream_feeder.sv
// Randomized bench for pr_bitstream_feeder: a ROM model, a reactive PR IP
// model and a word-order reference (word k of a run is ROM[k]).
module tb_pr_bitstream_feeder;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, error;
  logic [AW-1:0] num_words;
  logic [2:0]    err_code;

  pr_bitstream_feeder_if #(.ADDR_W(AW)) bus ();

  pr_bitstream_feeder #(.ADDR_W(AW), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .bus(bus)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nfail = 0;
  logic [15:0] rom_base = 16'hA000, rom_step = 16'h0001;

  // ROM: content is base + addr*step, data one cycle after the strobe.
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_rd ? rom_base + 16'(bus.mem_addr) * rom_step : 16'($urandom);

  function automatic logic [15:0] exp_word(input int k);
    return rom_base + 16'(k) * rom_step;
  endfunction

  logic [15:0] got[$];
  int          got_cyc[$];
  int          ps_cnt, rd_issued, xfers, stab_bad, out_bad, addr_bad, post_err, both_bad;
  bit          timed_out;

  // Run one reconfiguration: the PR model raises 100 in the st_delay-th
  // pr_start cycle (0 = never), 101 once all words arrived (unless no_succ),
  // err_val once err_at words arrived (0 = never).
  task automatic run_op(input int n, input int rdy_mode, input int st_delay, input int err_at,
                        input logic [2:0] err_val, input bit no_succ, input bit inj_start,
                        input int budget);
    bit started = 0, prev_stall = 0, injected = 0;
    logic [15:0] prev_data = '0;
    int tail = 0;
    got.delete(); got_cyc.delete();
    ps_cnt = 0; rd_issued = 0; xfers = 0; stab_bad = 0; out_bad = 0; addr_bad = 0;
    post_err = 0; both_bad = 0; timed_out = 1;
    @(negedge clk);
    start = 1; num_words = AW'(n); bus.pr_status = 3'b000; bus.pr_data_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      start = 0;
      case (rdy_mode)
        0:       bus.pr_data_ready = 1'b1;
        1:       bus.pr_data_ready = (c % 2 == 0);
        default: bus.pr_data_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.pr_start && st_delay > 0 && ps_cnt + 1 >= st_delay) started = 1;
      if (err_at > 0 && xfers >= err_at)        bus.pr_status = err_val;
      else if (n > 0 && xfers == n && !no_succ) bus.pr_status = 3'b101;
      else                                      bus.pr_status = started ? 3'b100 : 3'b000;
      if (inj_start && !injected && xfers == 2) begin
        start = 1; num_words = AW'($urandom_range(1, 30)); injected = 1;
      end
      #1;
      if (bus.pr_start) ps_cnt++;
      if (bus.mem_rd) begin
        if (bus.mem_addr !== AW'(rd_issued)) addr_bad++;
        rd_issued++;
      end
      if (prev_stall && bus.pr_data_valid && bus.pr_data !== prev_data) stab_bad++;
      if (bus.pr_data_valid && bus.pr_data_ready) begin
        got.push_back(bus.pr_data); got_cyc.push_back(c); xfers++;
      end
      if (rd_issued - xfers > 2) out_bad++;
      if (error && (bus.mem_rd || bus.pr_data_valid)) post_err++;
      if (done && error) both_bad++;
      prev_stall = bus.pr_data_valid && !bus.pr_data_ready;
      prev_data  = bus.pr_data;
      if ((done || error) && !busy) tail++;
      if (tail > 3) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; num_words = '0; bus.pr_data_ready = 0; bus.pr_status = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    nvec++; if ({bus.pr_start, bus.pr_data_valid, bus.mem_rd, busy, done, error} !== 6'b0) begin
      nfail++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.pr_start, bus.pr_data_valid, bus.mem_rd, busy, done, error}); end
    nvec++; if (err_code !== 3'b000) begin nfail++; $display("FAIL reset_err_code: got %b want 000", err_code); end
    nvec++; if (bus.pr_data !== 16'h0) begin nfail++; $display("FAIL reset_pr_data: got %h want 0000", bus.pr_data); end
    nvec++; if (bus.mem_addr !== '0) begin nfail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    rst = 0;
  endtask

  task automatic test_basic();
    rom_base = 16'hA000; rom_step = 16'h0001;
    run_op(4, 0, 3, 0, 3'b000, 0, 0, 200);
    nvec++; if (timed_out) begin nfail++; $display("FAIL basic_timeout: run did not finish"); end
    nvec++; if (ps_cnt != 3) begin nfail++; $display("FAIL basic_pr_start_cycles: got %0d want 3", ps_cnt); end
    nvec++; if (got.size() != 4) begin nfail++; $display("FAIL basic_count: got %0d want 4", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL basic_word[%0d]: got %h want %h", k, got[k], exp_word(k)); end
    end
    if (got.size() == 4) begin
      nvec++; if (got_cyc[3] - got_cyc[0] != 3) begin nfail++; $display("FAIL basic_throughput: span %0d want 3", got_cyc[3] - got_cyc[0]); end
    end
    nvec++; if ({done, error, busy} !== 3'b100) begin nfail++; $display("FAIL basic_flags: got %b want 100", {done, error, busy}); end
  endtask

  task automatic test_backpressure();
    rom_base = 16'($urandom); rom_step = 16'($urandom) | 16'h1;
    run_op(8, 1, 2, 0, 3'b000, 0, 0, 300);
    nvec++; if (got.size() != 8) begin nfail++; $display("FAIL bp_count: got %0d want 8", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL bp_word[%0d]: got %h want %h", k, got[k], exp_word(k)); end
    end
    nvec++; if (stab_bad != 0) begin nfail++; $display("FAIL bp_stable: got %0d changes want 0", stab_bad); end
    nvec++; if (out_bad != 0) begin nfail++; $display("FAIL bp_outstanding: got %0d overruns want 0", out_bad); end
    nvec++; if (addr_bad != 0) begin nfail++; $display("FAIL bp_addr: got %0d bad addresses want 0", addr_bad); end
    nvec++; if ({done, error} !== 2'b10) begin nfail++; $display("FAIL bp_flags: got %b want 10", {done, error}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 24);
      int sd = $urandom_range(1, 6);
      rom_base = 16'($urandom); rom_step = 16'($urandom);
      run_op(n, 2, sd, 0, 3'b000, 0, 0, 600);
      nvec++; if (got.size() != n) begin nfail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got.size(), n); end
      for (int k = 0; k < got.size(); k++) begin
        nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL rnd%0d_word[%0d]: got %h want %h", it, k, got[k], exp_word(k)); end
      end
      nvec++; if (ps_cnt != sd) begin nfail++; $display("FAIL rnd%0d_pr_start: got %0d want %0d", it, ps_cnt, sd); end
      nvec++; if (stab_bad + out_bad + addr_bad + both_bad != 0) begin nfail++;
        $display("FAIL rnd%0d_protocol: stab %0d out %0d addr %0d both %0d want 0", it, stab_bad, out_bad, addr_bad, both_bad); end
      nvec++; if ({done, error} !== 2'b10) begin nfail++; $display("FAIL rnd%0d_flags: got %b want 10", it, {done, error}); end
    end
  endtask

  task automatic test_status_error();
    for (int it = 0; it < 4; it++) begin
      int n = (it == 0) ? 16 : $urandom_range(2, 20);
      int ea = (it == 0) ? 5 : $urandom_range(1, n - 1);
      logic [2:0] ev = (it == 0) ? 3'b010 : 3'($urandom_range(1, 3));
      rom_base = 16'($urandom); rom_step = 16'($urandom);
      run_op(n, (it == 0) ? 0 : 2, 2, ea, ev, 0, 0, 400);
      nvec++; if ({error, done, busy} !== 3'b100) begin nfail++; $display("FAIL err%0d_flags: got %b want 100", it, {error, done, busy}); end
      nvec++; if (err_code !== ev) begin nfail++; $display("FAIL err%0d_code: got %b want %b", it, err_code, ev); end
      nvec++; if (post_err != 0) begin nfail++; $display("FAIL err%0d_activity: got %0d active cycles want 0", it, post_err); end
      nvec++; if (got.size() < ea || got.size() > ea + 1) begin nfail++;
        $display("FAIL err%0d_count: got %0d want %0d..%0d", it, got.size(), ea, ea + 1); end
      for (int k = 0; k < got.size(); k++) begin
        nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL err%0d_word[%0d]: got %h want %h", it, k, got[k], exp_word(k)); end
      end
    end
  endtask

  task automatic test_timeout();
    run_op(3, 0, 0, 0, 3'b000, 0, 0, 150);
    nvec++; if (ps_cnt != 50) begin nfail++; $display("FAIL tmo_start_cycles: got %0d want 50", ps_cnt); end
    nvec++; if ({error, err_code} !== 4'b1110) begin nfail++; $display("FAIL tmo_start_err: got %b want 1110", {error, err_code}); end
    nvec++; if (got.size() != 0) begin nfail++; $display("FAIL tmo_start_words: got %0d want 0", got.size()); end
    run_op(2, 0, 2, 0, 3'b000, 1, 0, 200);
    nvec++; if (got.size() != 2) begin nfail++; $display("FAIL tmo_fin_words: got %0d want 2", got.size()); end
    nvec++; if ({error, done, err_code} !== 5'b10110) begin nfail++; $display("FAIL tmo_fin_err: got %b want 10110", {error, done, err_code}); end
  endtask

  task automatic test_zero_and_ignore();
    run_op(0, 0, 1, 0, 3'b000, 0, 0, 50);
    nvec++; if ({error, done, err_code} !== 5'b10111) begin nfail++; $display("FAIL zero_err: got %b want 10111", {error, done, err_code}); end
    nvec++; if (ps_cnt != 0) begin nfail++; $display("FAIL zero_pr_start: got %0d want 0", ps_cnt); end
    rom_base = 16'($urandom); rom_step = 16'($urandom);
    run_op(10, 0, 2, 0, 3'b000, 0, 1, 300);
    nvec++; if (got.size() != 10) begin nfail++; $display("FAIL ignore_count: got %0d want 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL ignore_word[%0d]: got %h want %h", k, got[k], exp_word(k)); end
    end
    nvec++; if ({done, error} !== 2'b10) begin nfail++; $display("FAIL ignore_flags: got %b want 10", {done, error}); end
  endtask

  task automatic test_midstream_reset();
    int reads = 0;
    bit hit = 0;
    rom_base = 16'($urandom); rom_step = 16'($urandom);
    @(negedge clk);
    start = 1; num_words = AW'(10); bus.pr_status = 3'b000; bus.pr_data_ready = 1'b1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      bus.pr_status = busy ? 3'b100 : 3'b000;
      #1;
      if (bus.mem_rd) reads++;
      if (reads == 3) hit = 1;
      else @(negedge clk);
    end
    nvec++; if (!hit) begin nfail++; $display("FAIL rst_mid_reach: got no third read want one"); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    nvec++; if ({bus.pr_start, bus.pr_data_valid, bus.mem_rd, busy, done, error, err_code} !== 9'b0) begin nfail++;
      $display("FAIL rst_mid_ctrl: got %b want 0", {bus.pr_start, bus.pr_data_valid, bus.mem_rd, busy, done, error, err_code}); end
    nvec++; if ({bus.pr_data, 16'(bus.mem_addr)} !== 32'h0) begin nfail++;
      $display("FAIL rst_mid_data: got %h/%h want 0/0", bus.pr_data, bus.mem_addr); end
    rom_base = 16'($urandom);
    run_op(5, 0, 2, 0, 3'b000, 0, 0, 200);
    nvec++; if (got.size() != 5) begin nfail++; $display("FAIL rst_rerun_count: got %0d want 5", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      nvec++; if (got[k] !== exp_word(k)) begin nfail++; $display("FAIL rst_rerun_word[%0d]: got %h want %h", k, got[k], exp_word(k)); end
    end
    nvec++; if ({done, error, addr_bad != 0} !== 3'b100) begin nfail++;
      $display("FAIL rst_rerun_flags: got %b want 100", {done, error, addr_bad != 0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_status_error();
    test_timeout();
    test_zero_and_ignore();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
